seg_scan_capture: RTL

//  Receiving end of the multiplexed 7-segment display interface. Samples the

---
 rtl/seg_scan_capture.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Receiving end of a multiplexed, active-low 4-digit 7-segment interface.
//   It synchronises the anode strobes and segment lines, and samples each
//   digit once its anode has been stable. When all four digits are captured,
//   it publishes a frame.
//
// Ports
//   Clk          in   1   system clock
//   reset        in   1   synchronous reset, active-high
//   anode        in   4   digit enables, active-low; anode[3] = digit 3 (leftmost)
//   seg          in   8   cathodes, active-low; seg[6:0] = {g,f,e,d,c,b,a}, seg[7] = dp
//   frame_seg    out  32  captured raw segments, byte n = digit n
//   frame_valid  out  1   one-cycle pulse when frame_seg / frame_hex update
//   ghost_err    out  1   sticky flag: more than one anode low was seen
//   frame_hex    out  16  decoded nibbles, digit n in [4n+3:4n]
//   frame_hex_ok out  4   bit n set when digit n matched a hex glyph
//
// Build option
//   SEG_SCAN_HEX_DECODE_EN : when defined, the hex glyph decoder is built.
//                            When not defined, frame_hex and frame_hex_ok are tied to 0.

module seg_scan_capture #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [7:0]  seg,
  output logic [31:0] frame_seg,
  output logic        frame_valid,
  output logic        ghost_err,
  output logic [15:0] frame_hex,
  output logic [3:0]  frame_hex_ok
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  logic [3:0]  r_an_sync  [SYNC_STAGES];
  logic [7:0]  r_seg_sync [SYNC_STAGES];

  state_t      r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic [3:0]  r_cur, w_cur_nx;
  logic [3:0]  r_mask;
  logic [7:0]  r_slot [4];
  logic [31:0] r_frame_seg;
  logic        r_frame_valid;
  logic        r_ghost;

  logic [3:0]  w_an;
  logic [7:0]  w_seg;
  logic [3:0]  w_zero;
  logic        w_multi;
  logic        w_valid;
  logic        w_cap;
  logic        w_enter;
  logic        w_full;
  logic [3:0]  w_cap_bit;

  // Synchronisers reset to all-ones (blank, idle level).
  // This keeps the cleared pipeline from looking like a multi-anode ghost.
  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_an_sync[i]  <= '1;
        r_seg_sync[i] <= '1;
      end
    end else begin
      r_an_sync[0]  <= anode;
      r_seg_sync[0] <= seg;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_an_sync[i]  <= r_an_sync[i-1];
        r_seg_sync[i] <= r_seg_sync[i-1];
      end
    end
  end

  assign w_an    = r_an_sync[SYNC_STAGES-1];
  assign w_seg   = r_seg_sync[SYNC_STAGES-1];
  assign w_zero  = ~w_an;
  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign w_multi = |(w_zero & (w_zero - 4'd1));
  assign w_valid = (w_zero != '0) && !w_multi;

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cur   <= '1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_cur   <= w_cur_nx;
    end
  end

  // HOLD and an aborted SETTLE both fall back to the IDLE entry path (w_enter).
  // A change straight to another valid anode therefore starts settling in the same cycle.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cur_nx   = r_cur;
    w_cap      = 1'b0;
    w_enter    = 1'b0;
    unique case (r_state)
      S_IDLE:   w_enter = 1'b1;
      S_SETTLE: begin
        if (w_an != r_cur) begin
          w_enter = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_cap      = 1'b1;
          w_state_nx = S_HOLD;
        end else begin
          w_cnt_nx = r_cnt + 4'd1;
        end
      end
      S_HOLD:   if (w_an != r_cur) w_enter = 1'b1;
      default:  w_state_nx = S_IDLE;
    endcase
    if (w_enter) begin
      if (w_valid) begin
        w_cur_nx = w_an;
        w_cnt_nx = 4'd1;
        if (SETTLE_CYCLES <= 1) begin
          w_cap      = 1'b1;
          w_state_nx = S_HOLD;
        end else begin
          w_state_nx = S_SETTLE;
        end
      end else begin
        w_state_nx = S_IDLE;
      end
    end
    if (w_multi) begin
      w_state_nx = S_IDLE;
      w_cap      = 1'b0;
    end
  end

  assign w_full    = (r_mask == 4'hF);
  // A valid anode is one-hot low, so its inverse is the slot select.
  assign w_cap_bit = w_cap ? w_zero : '0;

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_mask        <= '0;
      r_frame_seg   <= '0;
      r_frame_valid <= 1'b0;
      r_ghost       <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) r_slot[i] <= '0;
    end else begin
      r_frame_valid <= w_full;
      if (w_full) r_frame_seg <= {r_slot[3], r_slot[2], r_slot[1], r_slot[0]};
      // A capture that lands on the copy cycle survives into the next frame's mask.
      r_mask <= (w_full ? 4'h0 : r_mask) | w_cap_bit;
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_cap_bit[i]) r_slot[i] <= w_seg;
      end
      if (w_multi) r_ghost <= 1'b1;
    end
  end

  assign frame_seg   = r_frame_seg;
  assign frame_valid = r_frame_valid;
  assign ghost_err   = r_ghost;

`ifdef SEG_SCAN_HEX_DECODE_EN
  logic [15:0] r_frame_hex;
  logic [3:0]  r_frame_hex_ok;

  // Returns {match, nibble}. The dp bit is ignored.
  function automatic logic [4:0] hex_decode(input logic [7:0] s);
    logic [4:0] r;
    unique case (s[6:0])
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_frame_hex    <= '0;
      r_frame_hex_ok <= '0;
    end else if (w_full) begin
      for (int unsigned i = 0; i < 4; i++) begin
        {r_frame_hex_ok[i], r_frame_hex[4*i +: 4]} <= hex_decode(r_slot[i]);
      end
    end
  end

  assign frame_hex    = r_frame_hex;
  assign frame_hex_ok = r_frame_hex_ok;
`else
  assign frame_hex    = '0;
  assign frame_hex_ok = '0;
`endif

endmodule
